// File: rtl/alu_req_arbiter.sv
// Two-requester arbiter in front of a shared single-cycle 32-bit ALU, with a valid/ready response channel.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default build is round-robin.
module alu_req_arbiter #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned OTH_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_ctrl_i,
    input  logic [31:0] req0_data1_i,
    input  logic [31:0] req0_data2_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_ctrl_i,
    input  logic [31:0] req1_data1_i,
    input  logic [31:0] req1_data2_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  alu_ctrl_o,
    input  logic [31:0] alu_data_i,
    output logic        busy_o
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 3;
    localparam logic [CTRL_W-1:0] OP_MUL = 3'b011;
    localparam logic [CTRL_W-1:0] OP_ILL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                id_q, id_d;
    logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0]   alu_data1_q, alu_data1_d;
    logic [DATA_W-1:0]   alu_data2_q, alu_data2_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;

    logic                gnt_id_c;
    logic                accept_c;
    logic [CTRL_W-1:0]   sel_ctrl_c;
    logic [DATA_W-1:0]   sel_data1_c;
    logic [DATA_W-1:0]   sel_data2_c;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // req0 always wins; req1 only granted when req0 is idle.
    assign gnt_id_c = !req0_valid_i;
`else
    // last_q names the requester served most recently; reset treats req1 as last.
    logic last_q, last_d;

    assign gnt_id_c = (req0_valid_i && req1_valid_i) ? !last_q : req1_valid_i;

    always_comb begin
        last_d = last_q;
        if (accept_c) begin
            last_d = gnt_id_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign accept_c     = (state_q == ST_IDLE) && (req0_valid_i || req1_valid_i);
    assign req0_ready_o = (state_q == ST_IDLE) && req0_valid_i && !gnt_id_c;
    assign req1_ready_o = (state_q == ST_IDLE) && req1_valid_i && gnt_id_c;

    assign sel_ctrl_c  = gnt_id_c ? req1_ctrl_i  : req0_ctrl_i;
    assign sel_data1_c = gnt_id_c ? req1_data1_i : req0_data1_i;
    assign sel_data2_c = gnt_id_c ? req1_data2_i : req0_data2_i;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_data1_d = alu_data1_q;
        alu_data2_d = alu_data2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    id_d = gnt_id_c;
                    if (sel_ctrl_c == OP_ILL) begin
                        // Illegal op never reaches the ALU; answer immediately with an error.
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = gnt_id_c;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        alu_ctrl_d  = sel_ctrl_c;
                        alu_data1_d = sel_data1_c;
                        alu_data2_d = sel_data2_c;
                        cnt_d       = (sel_ctrl_c == OP_MUL) ? CNT_W'(MUL_LAT - 1)
                                                             : CNT_W'(OTH_LAT - 1);
                        state_d     = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = alu_data_i;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            alu_ctrl_q  <= '0;
            alu_data1_q <= '0;
            alu_data2_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_data1_q <= alu_data1_d;
            alu_data2_q <= alu_data2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_ctrl_o  = alu_ctrl_q;
    assign alu_data1_o = alu_data1_q;
    assign alu_data2_o = alu_data2_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural ALU hooked to the alu_* port pair.
module tb_alu_req_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [2:0]  req0_ctrl_i, req1_ctrl_i;
    logic [31:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_err_o, busy_o;
    logic [31:0] rsp_data_o, alu_data1_o, alu_data2_o, alu_data_i;
    logic [2:0]  alu_ctrl_o;

    int checks = 0;
    int errors = 0;

    alu_req_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_ctrl_i  (req0_ctrl_i),
        .req0_data1_i (req0_data1_i),
        .req0_data2_i (req0_data2_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_ctrl_i  (req1_ctrl_i),
        .req1_data1_i (req1_data1_i),
        .req1_data2_i (req1_data2_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .alu_data1_o  (alu_data1_o),
        .alu_data2_o  (alu_data2_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_data_i   (alu_data_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural single-cycle ALU.
    always_comb begin
        alu_data_i = 32'h0;
        case (alu_ctrl_o)
            3'b000: alu_data_i = alu_data1_o & alu_data2_o;
            3'b001: alu_data_i = alu_data1_o ^ alu_data2_o;
            3'b010: alu_data_i = alu_data1_o + alu_data2_o;
            3'b011: alu_data_i = alu_data1_o * alu_data2_o;
            3'b100: alu_data_i = $signed(alu_data1_o) >>> alu_data2_o[4:0];
            3'b110: alu_data_i = alu_data1_o - alu_data2_o;
            3'b111: alu_data_i = alu_data1_o << alu_data2_o[4:0];
            default: alu_data_i = 32'h0;
        endcase
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          n;
    logic        exp_id;
    logic [31:0] exp_data;

    initial begin
        rst_i = 1'b0;
        req0_valid_i = 1'b0; req0_ctrl_i = 3'b000; req0_data1_i = '0; req0_data2_i = '0;
        req1_valid_i = 1'b0; req1_ctrl_i = 3'b000; req1_data1_i = '0; req1_data2_i = '0;
        rsp_ready_i = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_alu_ctrl",  32'(alu_ctrl_o),  32'd0);
        chk("rst_rsp_data",  rsp_data_o,       32'd0);
        rst_i = 1'b1;
        tick();

        // Single ADD from req0: 5 + 7
        req0_valid_i = 1'b1; req0_ctrl_i = 3'b010; req0_data1_i = 32'd5; req0_data2_i = 32'd7;
        #1;
        chk("add_ready0", 32'(req0_ready_o), 32'd1);
        tick();
        req0_valid_i = 1'b0;
        chk("add_busy_t1",  32'(busy_o),      32'd1);
        chk("add_valid_t1", 32'(rsp_valid_o), 32'd0);
        chk("add_alu_ctrl", 32'(alu_ctrl_o),  32'd2);
        chk("add_alu_d1",   alu_data1_o,      32'd5);
        tick();
        chk("add_valid_t2", 32'(rsp_valid_o), 32'd1);
        chk("add_data",     rsp_data_o,       32'd12);
        chk("add_id",       32'(rsp_id_o),    32'd0);
        chk("add_err",      32'(rsp_err_o),   32'd0);
        chk("add_busy_t2",  32'(busy_o),      32'd1);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("add_done_valid", 32'(rsp_valid_o), 32'd0);
        chk("add_done_busy",  32'(busy_o),      32'd0);
        chk("add_alu_retain", alu_data2_o,      32'd7);

        // MUL from req1: 6 * -3
        req1_valid_i = 1'b1; req1_ctrl_i = 3'b011; req1_data1_i = 32'd6; req1_data2_i = 32'hFFFF_FFFD;
        #1;
        chk("mul_ready1", 32'(req1_ready_o), 32'd1);
        tick();
        req1_valid_i = 1'b0;
        chk("mul_valid_t1", 32'(rsp_valid_o), 32'd0);
        chk("mul_alu_ctrl", 32'(alu_ctrl_o),  32'd3);
        chk("mul_alu_d2",   alu_data2_o,      32'hFFFF_FFFD);
        tick();
        chk("mul_valid_t2", 32'(rsp_valid_o), 32'd0);
        chk("mul_alu_d1_t2", alu_data1_o,     32'd6);
        chk("mul_alu_d2_t2", alu_data2_o,     32'hFFFF_FFFD);
        tick();
        chk("mul_valid_t3", 32'(rsp_valid_o), 32'd1);
        chk("mul_data",     rsp_data_o,       32'hFFFF_FFEE);
        chk("mul_id",       32'(rsp_id_o),    32'd1);
        rsp_ready_i = 1'b1;
        tick();

        // Contention: both valid continuously, response always ready
        req0_valid_i = 1'b1; req0_ctrl_i = 3'b010; req0_data1_i = 32'd1;  req0_data2_i = 32'd2;
        req1_valid_i = 1'b1; req1_ctrl_i = 3'b010; req1_data1_i = 32'd10; req1_data2_i = 32'd20;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (rsp_valid_o !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            chk("cont_wait", 32'(n < 10), 32'd1);
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = 1'(k % 2);
`endif
            exp_data = exp_id ? 32'd30 : 32'd3;
            chk("cont_id",   32'(rsp_id_o), 32'(exp_id));
            chk("cont_data", rsp_data_o,    exp_data);
            tick();
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        tick();
        chk("cont_idle", 32'(busy_o), 32'd0);

        // Backpressure: response held for 5 cycles with both requesters waiting
        req0_valid_i = 1'b1; req0_ctrl_i = 3'b010; req0_data1_i = 32'd100; req0_data2_i = 32'd23;
        req1_valid_i = 1'b0;
        #1;
        chk("bp_ready0", 32'(req0_ready_o), 32'd1);
        tick();
        req0_valid_i = 1'b0;
        tick();
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid",  32'(rsp_valid_o),  32'd1);
            chk("bp_data",   rsp_data_o,        32'd123);
            chk("bp_id",     32'(rsp_id_o),     32'd0);
            chk("bp_ready0", 32'(req0_ready_o), 32'd0);
            chk("bp_ready1", 32'(req1_ready_o), 32'd0);
            tick();
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        chk("bp_still_valid", 32'(rsp_valid_o), 32'd1);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("bp_done_valid", 32'(rsp_valid_o), 32'd0);
        chk("bp_done_busy",  32'(busy_o),      32'd0);

        // Illegal op from req1, then a legal XOR
        req1_valid_i = 1'b1; req1_ctrl_i = 3'b101; req1_data1_i = 32'hDEAD; req1_data2_i = 32'hBEEF;
        #1;
        chk("ill_ready1", 32'(req1_ready_o), 32'd1);
        tick();
        req1_valid_i = 1'b0;
        chk("ill_valid",    32'(rsp_valid_o), 32'd1);
        chk("ill_data",     rsp_data_o,       32'd0);
        chk("ill_err",      32'(rsp_err_o),   32'd1);
        chk("ill_id",       32'(rsp_id_o),    32'd1);
        chk("ill_alu_ctrl", 32'(alu_ctrl_o),  32'd2);
        chk("ill_alu_d1",   alu_data1_o,      32'd100);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        req0_valid_i = 1'b1; req0_ctrl_i = 3'b001; req0_data1_i = 32'h0000_F0F0; req0_data2_i = 32'h0000_0FF0;
        #1;
        chk("xor_ready0", 32'(req0_ready_o), 32'd1);
        tick();
        req0_valid_i = 1'b0;
        tick();
        chk("xor_valid", 32'(rsp_valid_o), 32'd1);
        chk("xor_data",  rsp_data_o,       32'h0000_FF00);
        chk("xor_err",   32'(rsp_err_o),   32'd0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Reset during MUL EXEC
        req0_valid_i = 1'b1; req0_ctrl_i = 3'b011; req0_data1_i = 32'd3; req0_data2_i = 32'd4;
        tick();
        req0_valid_i = 1'b0;
        chk("mrst_busy_pre", 32'(busy_o), 32'd1);
        rst_i = 1'b0;
        tick();
        chk("mrst_valid",    32'(rsp_valid_o), 32'd0);
        chk("mrst_busy",     32'(busy_o),      32'd0);
        chk("mrst_alu_ctrl", 32'(alu_ctrl_o),  32'd0);
        chk("mrst_alu_d1",   alu_data1_o,      32'd0);
        chk("mrst_rsp_data", rsp_data_o,       32'd0);
        rst_i = 1'b1;
        tick(); tick(); tick();
        chk("mrst_no_rsp", 32'(rsp_valid_o), 32'd0);
        req0_valid_i = 1'b1; req0_ctrl_i = 3'b110; req0_data1_i = 32'd9;  req0_data2_i = 32'd4;
        req1_valid_i = 1'b1; req1_ctrl_i = 3'b110; req1_data1_i = 32'd50; req1_data2_i = 32'd8;
        #1;
        chk("mrst_gnt0", 32'(req0_ready_o), 32'd1);
        chk("mrst_gnt1", 32'(req1_ready_o), 32'd0);
        tick();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        tick();
        chk("sub_valid", 32'(rsp_valid_o), 32'd1);
        chk("sub_data",  rsp_data_o,       32'd5);
        chk("sub_id",    32'(rsp_id_o),    32'd0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("end_idle", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
